// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl
//   Shares one BCD-to-one-of-ten decoder across NDIG digits of a multiplexed
//   indicator. A packed BCD word is accepted over valid/ready into a pending
//   buffer. It is promoted to the active buffer only at a frame boundary, or
//   on leaving IDLE, so the display never shows a mix of old and new digits.
//   Each digit is shown for DWELL cycles and is followed by a one-cycle blank.
//
// Ports
//   CLK, nRST        clock / synchronous active-high reset
//   Enable           scan enable; low drops to IDLE with blank outputs
//   LoadValid/Ready  load handshake; LoadReady = pending buffer empty
//   LoadData         packed BCD, digit i at [4i+3:4i], digit 0 scanned first
//   DigSel           one-hot digit select (registered), zero while blank
//   DECOut           one-of-ten decode of the active digit (registered)
//   DigErr           active digit is 10..15 (registered)
//   ScanDone         high during the blank that closes a frame (registered)
module bcd_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DWELL = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                Enable,
    input  logic                LoadValid,
    output logic                LoadReady,
    input  logic [4*NDIG-1:0]   LoadData,
    output logic [NDIG-1:0]     DigSel,
    output logic [9:0]          DECOut,
    output logic                DigErr,
    output logic                ScanDone
);

    localparam int              IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]   LAST    = IW'(NDIG - 1);
    localparam logic [7:0]      DW_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              dwell_q, dwell_d;
    logic [NDIG-1:0][3:0]    act_q, act_d;
    logic [NDIG-1:0][3:0]    pend_q, pend_d;
    logic                    act_vld_q, act_vld_d;
    logic                    pend_full_q, pend_full_d;
    logic [NDIG-1:0]         dig_sel_q, dig_sel_d;
    logic [9:0]              dec_q, dec_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic                    promote;
    logic [3:0]              digit;

    assign LoadReady = !pend_full_q;
    assign DigSel    = dig_sel_q;
    assign DECOut    = dec_q;
    assign DigErr    = err_q;
    assign ScanDone  = done_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_d     = dwell_q;
        act_d       = act_q;
        act_vld_d   = act_vld_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        promote     = 1'b0;

        // A load can only land while pending is empty, and a promote only
        // happens while pending is full, so the two never collide.
        if (LoadValid && !pend_full_q) begin
            pend_d      = LoadData;
            pend_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (Enable && (act_vld_q || pend_full_q)) begin
                    state_d = SHOW;
                    idx_d   = '0;
                    dwell_d = '0;
                    promote = pend_full_q;
                end
            end
            SHOW: begin
                if (!Enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    dwell_d = '0;
                end else if (dwell_q == DW_LAST) begin
                    state_d = BLANK;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            BLANK: begin
                if (!Enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    dwell_d = '0;
                end else if (idx_q == LAST) begin
                    state_d = SHOW;
                    idx_d   = '0;
                    promote = pend_full_q;
                end else begin
                    state_d = SHOW;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                dwell_d = '0;
            end
        endcase

        if (promote) begin
            act_d       = pend_q;
            act_vld_d   = 1'b1;
            pend_full_d = 1'b0;
        end

        // Outputs are computed from next-state values so that the registered
        // outputs line up with the state they describe.
        digit     = act_d[idx_d];
        dig_sel_d = '0;
        dec_d     = '0;
        err_d     = 1'b0;
        if (state_d == SHOW) begin
            dig_sel_d = {{(NDIG-1){1'b0}}, 1'b1} << idx_d;
            err_d     = (digit > 4'd9);
            if (digit <= 4'd9)
                dec_d = 10'b1 << digit;
        end
        done_d = (state_d == BLANK) && (idx_d == LAST);
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dwell_q     <= '0;
            act_vld_q   <= 1'b0;
            pend_full_q <= 1'b0;
            dig_sel_q   <= '0;
            dec_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            act_vld_q   <= act_vld_d;
            pend_full_q <= pend_full_d;
            dig_sel_q   <= dig_sel_d;
            dec_q       <= dec_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    // Buffer contents are qualified by the valid/full flags, so they need no reset.
    always_ff @(posedge CLK) begin
        act_q  <= act_d;
        pend_q <= pend_d;
    end

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Time-multiplexing controller that shares a single BCD-to-decimal (one-of-ten) decode path across NDIG BCD digits for a multiplexed indicator display. It accepts a packed multi-digit BCD word over a valid/ready handshake and double-buffers it. It then scans the digits round-robin with a programmable dwell and a one-cycle blanking gap. It sits between the value-producing logic (counters, arithmetic) and the digit-select/segment drivers.

## Interface
- NDIG, 4: number of BCD digits scanned (2..8).
- DWELL, 4: cycles each digit is displayed (1..255).
- CLK  input  1  clock; all logic on rising edge.
- nRST  input  1  reset, synchronous, active-high.
- Enable  input  1  scan enable; low forces blank/idle.
- LoadValid  input  1  LoadData valid this cycle.
- LoadReady  output  1  pending buffer empty; a transfer occurs when LoadValid && LoadReady at a rising edge.
- LoadData  input  4*NDIG  packed BCD; digit i = LoadData[4i+3:4i], digit 0 scanned first.
- DigSel  output  NDIG  one-hot active digit; all-zero when blanked.
- DECOut  output  10  one-of-ten decode of active digit; bit n set for value n; zero when blanked or digit > 9.
- DigErr  output  1  high while the active digit holds 10..15.
- ScanDone  output  1  one-cycle pulse at the end of each complete frame.

## Operation
- Registers: active buffer, active-valid flag, pending buffer, pending-full flag, state, digit index (width clog2(NDIG)), and dwell counter (8 bits).
- States: IDLE, SHOW, BLANK.
- Reset (nRST=1 at an edge) has the following effect:
  - state=IDLE, index=0, dwell=0.
  - active-valid=0, pending-full=0.
  - Outputs: DigSel=0, DECOut=0, DigErr=0, ScanDone=0, LoadReady=1.
  - Buffer contents are don't-care.
- Load: LoadReady = !pending-full. On a transfer, LoadData goes to the pending buffer and pending-full=1. LoadValid while LoadReady=0 is ignored, and the producer holds its data.
- IDLE transitions:
  - Goes to SHOW with index=0 and dwell=0 when Enable=1 and (active-valid or pending-full).
  - On that same edge, if pending-full, the pending buffer is promoted to active: active-valid=1, pending-full=0.
- SHOW behaviour:
  - DigSel=1<<index; DECOut=decode(active digit[index]); DigErr=(digit>9).
  - dwell increments each cycle.
  - When dwell reaches DWELL-1, go to BLANK and clear dwell.
- BLANK: DigSel=0, DECOut=0, DigErr=0 for exactly one cycle. Then:
  - If index<NDIG-1: index+1, go to SHOW.
  - If index=NDIG-1 (frame boundary):
    - ScanDone=1 for this cycle.
    - index=0; go to SHOW.
    - If pending-full, promote pending to active on this edge.
- Simultaneous load and promote on one edge: the promote takes the old pending contents; the incoming word is accepted only if LoadReady was 1 before the edge. Because LoadReady=0 whenever pending-full=1, no data is lost.
- Enable=0 in SHOW or BLANK: next edge goes to IDLE with outputs blank, index=0, dwell=0; no ScanDone. Buffers are retained, and loads still accepted in IDLE.
- Reset mid-frame: buffers are invalidated and the frame is abandoned; no ScanDone.

## Timing
- Outputs are registered: the values for a state are visible in the cycle after the edge that entered it.
- Frame length is NDIG*(DWELL+1) cycles; ScanDone recurs with that period while Enable=1.
- Startup latency: load accepted at edge k with Enable=1 in IDLE → promote and SHOW at edge k+1 → digit 0 visible after edge k+1.
- New data loaded mid-frame first appears on digit 0 of the next frame; the current frame completes with the old data, so there is no tearing.
- Only one new word is accepted per frame. LoadReady returns to 1 the cycle after the promote.

## Test plan
- Reset: hold nRST=1 for 2 cycles with LoadValid=1 → DigSel=0, DECOut=0, DigErr=0, ScanDone=0, LoadReady=1; no transfer.
- Basic frame (NDIG=4, DWELL=4), Enable=1:
  - Stimulus: load LoadData=16'h1234.
  - Required DigSel/DECOut sequence: 0001/10'h010 for 4 cycles, blank 1 cycle, 0010/10'h008, 0100/10'h004, 1000/10'h002.
  - ScanDone pulses on the final blank; period is 20 cycles.
- Invalid digits: load 16'hF9A0 → digit0 gives DECOut=10'h001; digit1 DECOut=0 with DigErr=1; digit2 DECOut=10'h200; digit3 DigErr=1.
- Double-buffer backpressure:
  - Load 16'h1111 and then 16'h2222 mid-frame; a third LoadValid sees LoadReady=0 and is not accepted.
  - 1s complete the frame; 2s start at digit 0 after ScanDone; LoadReady rises the next cycle.
- Enable drop: deassert Enable during digit 2's dwell → IDLE next edge, outputs blank, no ScanDone. Re-enable → scan restarts at digit 0 with the same data.
- Mid-frame reset: nRST=1 during SHOW of digit 1 → outputs blank next edge and LoadReady=1. With Enable=1 and no new load, the block stays IDLE.
